// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   ST_IDLE / ST_SHIFT / ST_DONE : FSM state encoding
//   cnt_w(width)                 : bit count needed for a counter reaching 'width'
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // The counter must be able to hold WIDTH itself, because it still
  // increments on the final shift cycle.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full subtractor cell: diff = a - b - bin, with borrow-out.
// Latency: combinational, zero cycles.
// Backpressure: none, pure combinational cell.
//
// Ports (output-first, matching the adder cell):
//   diff : difference bit
//   bout : borrow out
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin mod 2^WIDTH, LSB first, one bit per clock.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+WIDTH+1.
// Backpressure: none; start is only honoured in IDLE, requests while busy are dropped.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : operation request, sampled only in IDLE
//   a, b, bin       : operands, latched when start is accepted
//   busy            : high while bits are being shifted
//   done            : one-cycle pulse, results valid from here to the next accepted start
//   diff, bout, ovf : result, final borrow, signed overflow
//
// Build option: define SERIAL_SUB_OVF_EN to compute ovf; otherwise ovf is tied to 0.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int              CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             br_nx;
  logic             last_bit;
  logic             accept;

  full_subtractor u_cell (
    .diff (d_bit),
    .bout (br_nx),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br)
  );

  assign busy     = (state == ST_SHIFT);
  assign last_bit = (state == ST_SHIFT) && (cnt == LAST);
  assign accept   = (state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            bout  <= 1'b0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Entering at the MSB and shifting right leaves bit 0 of the
          // result in diff[0] after WIDTH cycles.
          diff <= {d_bit, diff[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nx;
          bout <= br_nx;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last shift the cell sees the operand sign bits and produces the
  // result sign bit; overflow when operand signs differ and the result sign
  // differs from the minuend's.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int tests  = 0;
  int errors = 0;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_80_01 = 1'b1;
`else
  localparam logic OVF_80_01 = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  // Stimulus only: pulses start for one cycle, then counts negedges until
  // done is seen (bounded). Returns the latency and whether busy and done
  // ever overlapped. Inputs change at negedge, outputs are sampled there too.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bv_in, output int cyc, output bit overlap);
    @(negedge clk);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    overlap = 1'b0;
    while (!done && cyc < 40) begin
      if (busy && done) overlap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, diff, bout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
  endtask

  task automatic test_basic();
    int cyc; bit ov;
    run_op(8'd10, 8'd3, 1'b0, cyc, ov);
    tests++;
    if (cyc !== W + 2) begin
      errors++; $display("FAIL latency_10_3: got %0d cycles, want %0d", cyc, W + 2);
    end
    tests++;
    if ({diff, bout, ovf} !== {8'd7, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_10_3: got diff=%h bout=%b ovf=%b, want 07 0 0", diff, bout, ovf);
    end
    tests++;
    if (ov !== 1'b0) begin
      errors++; $display("FAIL busy_done_overlap: got %b, want 0", ov);
    end
    // done must drop after one cycle; results hold while idle
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle: got done=%b, want 0", done);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, diff, bout} !== {1'b0, 8'd7, 1'b0}) begin
      errors++; $display("FAIL hold_idle: got busy=%b diff=%h bout=%b, want 0 07 0", busy, diff, bout);
    end
  endtask

  task automatic test_wrap();
    int cyc; bit ov;
    run_op(8'd3, 8'd10, 1'b0, cyc, ov);
    tests++;
    if ({diff, bout, ovf} !== {8'hF9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_3_10: got diff=%h bout=%b ovf=%b, want f9 1 0", diff, bout, ovf);
    end
    run_op(8'h00, 8'h00, 1'b1, cyc, ov);
    tests++;
    if ({diff, bout} !== {8'hFF, 1'b1}) begin
      errors++; $display("FAIL sub_0_0_bin: got diff=%h bout=%b, want ff 1", diff, bout);
    end
    run_op(8'hFF, 8'hFF, 1'b0, cyc, ov);
    tests++;
    if ({diff, bout} !== {8'h00, 1'b0}) begin
      errors++; $display("FAIL sub_ff_ff: got diff=%h bout=%b, want 00 0", diff, bout);
    end
  endtask

  task automatic test_ovf();
    int cyc; bit ov;
    run_op(8'h80, 8'h01, 1'b0, cyc, ov);
    tests++;
    if ({diff, bout, ovf} !== {8'h7F, 1'b0, OVF_80_01}) begin
      errors++; $display("FAIL sub_80_01: got diff=%h bout=%b ovf=%b, want 7f 0 %b",
                         diff, bout, ovf, OVF_80_01);
    end
    // overflow flag must clear on the next normal operation
    run_op(8'd10, 8'd3, 1'b0, cyc, ov);
    tests++;
    if ({diff, ovf} !== {8'd7, 1'b0}) begin
      errors++; $display("FAIL ovf_clear: got diff=%h ovf=%b, want 07 0", diff, ovf);
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int cyc; bit ov;
    @(negedge clk);
    a = 8'd5; b = 8'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_in_shift: got busy=%b, want 1", busy);
    end
    @(negedge clk);
    a = 8'd9; b = 8'd9; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      if (done) begin
        dones++;
        tests++;
        if ({diff, bout} !== {8'd3, 1'b0}) begin
          errors++; $display("FAIL midshift_result: got diff=%h bout=%b, want 03 0", diff, bout);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (dones !== 1) begin
      errors++; $display("FAIL midshift_done_count: got %0d, want 1", dones);
    end
    run_op(8'd100, 8'd1, 1'b0, cyc, ov);
    tests++;
    if ({cyc, diff} !== {W + 2, 8'd99}) begin
      errors++; $display("FAIL after_ignore: got cyc=%0d diff=%h, want %0d 63", cyc, diff, W + 2);
    end
  endtask

  task automatic test_reset_mid_shift();
    int dones = 0;
    int cyc; bit ov;
    @(negedge clk);
    a = 8'd200; b = 8'd7; bin = 1'b0; start = 1'b1;
    @(negedge clk);   // first SHIFT cycle
    start = 1'b0;
    repeat (3) @(negedge clk);   // fourth SHIFT cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, diff, bout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_shift: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    for (int i = 0; i < W + 6; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    tests++;
    if (dones !== 0) begin
      errors++; $display("FAIL no_done_after_reset: got %0d active cycles, want 0", dones);
    end
    run_op(8'd20, 8'd5, 1'b0, cyc, ov);
    tests++;
    if ({cyc, diff, bout} !== {W + 2, 8'd15, 1'b0}) begin
      errors++; $display("FAIL after_reset_op: got cyc=%0d diff=%h bout=%b, want %0d 0f 0",
                         cyc, diff, bout, W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ovf();
    test_start_ignored();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
